spi_reg_slave: RTL
==================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter WHO_AM_I, default 8'h33, meaning the constant returned at address 0x0F.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on the SPI inputs (minimum 2).
REQ-003 clk12m  input  1  sole clock, 12 MHz; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spi_sclk  input  1  external master SPI clock, mode 3 (idles high), max 1 MHz.
REQ-006 spi_cs_n  input  1  chip select, active-low.
REQ-007 spi_mosi  input  1  master-to-slave data, MSB first.
REQ-008 spi_miso  output  1  slave-to-master data, MSB first.
REQ-009 spi_miso_oe  output  1  MISO output enable; the top level tri-states the pad when this is 0.
REQ-010 status  input  8  fabric status byte, readable at 0x0E.
REQ-011 wr_stb  output  1  one-cycle pulse per committed register write.
REQ-012 wr_addr  output  6  address of the committed write, valid while wr_stb=1.
REQ-013 wr_data  output  8  data of the committed write, valid while wr_stb=1.
REQ-014 busy  output  1  synchronized CS active, meaning a transaction is in progress.

Function
REQ-015 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops, then edge-detect sclk rising and falling edges in the clk12m domain.
REQ-016 SHALL implement the states IDLE, CMD and DATA; IDLE->CMD on synchronized cs_n falling; CMD->DATA after 8 command bits; DATA persists until CS deasserts.
REQ-017 SHALL sample MOSI on each synchronized sclk rising edge and update MISO on each synchronized sclk falling edge; a 3-bit bit counter SHALL wrap every 8 rising edges.
REQ-018 Command byte format: bit7 RW (1=read), bit6 MS (1=auto-increment), bits5:0 start address.
REQ-019 Register map: 0x00-0x0D are R/W bytes; 0x0E returns status, sampled at the byte-load cycle; 0x0F returns WHO_AM_I; 0x10-0x3F read as 0x00.
REQ-020 Writes to 0x0E-0x3F SHALL be ignored (no register change, no wr_stb).
REQ-021 Read: the addressed byte SHALL be loaded into the TX shift register within 2 clk12m cycles of the 8th rising edge of the command byte or data byte. The first following falling edge drives bit7. Reads are snapshots taken at load time.
REQ-022 Write: on the 8th rising edge of each data byte, the write SHALL commit to the register file. wr_stb SHALL pulse 1 cycle, 1 cycle after that rising edge is detected.
REQ-023 With MS=1, the address SHALL increment after each complete data byte, wrapping from 0x3F to 0x00. With MS=0, the address stays fixed.
REQ-024 spi_miso_oe SHALL be 1 only while in DATA with RW=1; otherwise 0. spi_miso SHALL be 0 when spi_miso_oe=0.
REQ-025 CS deassert in any state SHALL return to IDLE within 1 cycle after the synchronized edge. The bit counter SHALL clear, partial bytes SHALL be discarded with no wr_stb, and spi_miso_oe SHALL drop to 0.
REQ-026 A CS deassert coincident with the 8th data rising edge SHALL still commit the write, because the rising edge precedes the CS edge in synchronized order.
REQ-027 busy SHALL equal the inverted synchronized cs_n.

Reset
REQ-028 While rst=1: state=IDLE, registers 0x00-0x0D=0x00, bit counter=0, spi_miso=0, spi_miso_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0.
REQ-029 rst asserted mid-transaction SHALL abort it with no write. After rst releases, the block SHALL ignore activity until the next cs_n falling edge.

Verification
REQ-030 Read command 0x8F -> MISO returns 0x33 in the next byte; spi_miso_oe=1 during the data byte only.
REQ-031 Write command 0x43 (MS=1, addr 0x03), then data 0xA5, 0x5A -> wr_stb pulses twice with (0x03,0xA5) and (0x04,0x5A); a following read command 0xC3 returns 0xA5, 0x5A.
REQ-032 Write command 0x7F (MS=1, addr 0x3F), then data 0x11, 0x22 -> no wr_stb for 0x3F; wr_stb (0x00,0x22); reading 0x00 returns 0x22.
REQ-033 Write to 0x05 with CS deasserted after 5 data bits -> no wr_stb; 0x05 still reads 0x00; spi_miso_oe=0.
REQ-034 status=0x5C, read command 0x8E -> MISO returns 0x5C; a write of 0xFF to 0x0E produces no wr_stb.
REQ-035 Write 0x77 to 0x01, pulse rst for 1 cycle, then read 0x01 -> returns 0x00; all outputs hold their reset values during rst.

Source files
------------

// File: rtl/spi_reg_slave.sv
// spi_reg_slave
//   SPI mode-3 register slave clocked entirely by clk12m. The SPI pins are
//   synchronized and sclk edges are detected in the clk12m domain.
//   Transactions consist of one command byte followed by any number of data bytes.
//   Command byte layout: bit7 RW (1=read), bit6 MS (1=auto-increment), bits5:0 address.
//
// Register map
//   0x00-0x0D  R/W bytes
//   0x0E       status input (read only, sampled at load time)
//   0x0F       WHO_AM_I (read only)
//   0x10-0x3F  read as 0x00; writes are ignored
//
// Ports
//   clk12m, rst          clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi   SPI inputs (asynchronous to clk12m)
//   spi_miso/miso_oe     SPI output and pad enable
//   status               fabric status byte
//   wr_stb/addr/data     one-cycle notification of each committed write
//   busy                 synchronized chip select is active
module spi_reg_slave #(
    parameter logic [7:0] WHO_AM_I    = 8'h33,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk12m,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] status,
    output logic       wr_stb,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] rx_byte;
    logic [7:0] tx_sr;
    logic       miso_q;
    logic       rw, ms;
    logic [5:0] addr;
    logic       load_req;
    logic       byte_done;
    logic [7:0] rd_data;
    logic [7:0] regs [0:13];

    // The synchronizers are not reset. If cs_n is held low through reset, the
    // chain does not replay a false falling edge after reset is released.
    always_ff @(posedge clk12m) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    // cs_d resets low. As a result, only a high-to-low transition seen after
    // reset can open a transaction.
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign rx_byte   = {shift_in, mosi_s};
    assign byte_done = (state != IDLE) && sclk_rise && (bit_cnt == 3'd7);

    always_comb begin
        rd_data = 8'h00;
        if (addr <= 6'd13)      rd_data = regs[addr[3:0]];
        else if (addr == 6'd14) rd_data = status;
        else if (addr == 6'd15) rd_data = WHO_AM_I;
    end

    always_ff @(posedge clk12m) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = CMD;
            CMD:     if (cs_rise) state_nxt = IDLE;
                     else if (byte_done) state_nxt = DATA;
            DATA:    if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk12m) begin
        if (rst) begin
            sclk_d   <= 1'b1;
            cs_d     <= 1'b0;
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
            tx_sr    <= 8'h00;
            miso_q   <= 1'b0;
            rw       <= 1'b0;
            ms       <= 1'b0;
            addr     <= 6'd0;
            load_req <= 1'b0;
            wr_stb   <= 1'b0;
            wr_addr  <= 6'd0;
            wr_data  <= 8'h00;
            for (int i = 0; i < 14; i++) regs[i] <= 8'h00;
        end else begin
            sclk_d   <= sclk_s;
            cs_d     <= cs_s;
            wr_stb   <= 1'b0;
            load_req <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= 3'd0;
                miso_q  <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    shift_in <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    if (state == CMD) begin
                        rw       <= rx_byte[7];
                        ms       <= rx_byte[6];
                        addr     <= rx_byte[5:0];
                        load_req <= rx_byte[7];
                    end else begin
                        if (!rw && addr <= 6'd13) begin
                            regs[addr[3:0]] <= rx_byte;
                            wr_stb          <= 1'b1;
                            wr_addr         <= addr;
                            wr_data         <= rx_byte;
                        end
                        if (ms) addr <= addr + 6'd1;
                        load_req <= rw;
                    end
                end
                if (sclk_fall && state == DATA && rw) begin
                    miso_q <= tx_sr[7];
                    tx_sr  <= {tx_sr[6:0], 1'b0};
                end
                // The load is one cycle behind the byte boundary, so the
                // address has already advanced. The next falling edge is
                // many cycles away.
                if (load_req) tx_sr <= rd_data;
                // A rising edge in the same cycle has already been handled
                // above. This is how a final byte coincident with CS release
                // still commits.
                if (cs_rise) begin
                    bit_cnt <= 3'd0;
                    miso_q  <= 1'b0;
                end
            end
        end
    end

    assign spi_miso_oe = (state == DATA) && rw;
    assign spi_miso    = miso_q & spi_miso_oe;
    assign busy        = ~cs_s & ~rst;

endmodule
